// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature macro: DATA_MEM_RAND_WAIT_EN (random extra wait states).
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // 8-bit Fibonacci LFSR: seed and tap mask for taps 8,6,5,4 (bits 7,5,4,3)
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Expand per-byte enables into a 32-bit bit mask
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/mem_wait_lfsr.sv
// 8-bit Fibonacci LFSR used to jitter wait states; steps once per advance.
module mem_wait_lfsr
  import data_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] lfsr_q, lfsr_d;

  // shift left, feedback is parity of tapped bits
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // LFSR register, reseeded on reset so the sequence repeats per reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: memory side of the CPU data port with an
// Avalon-style waitrequest handshake and configurable wait states.
// Optional feature macro: DATA_MEM_RAND_WAIT_EN adds 0..3 LFSR-driven
// extra wait cycles per request.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err,
  output logic        protocol_err
);

  localparam int IW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        is_rd_q, is_rd_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        perr_q, perr_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic [3:0]  wait_load;
  logic [31:0] offset;
  logic        in_range, aligned, bad;
  logic [IW-1:0] idx;

  assign accept = (state_q == IDLE) && (read || write);

`ifdef DATA_MEM_RAND_WAIT_EN
  logic [7:0] lfsr;
  logic [4:0] wait_sum;

  mem_wait_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .value   (lfsr)
  );

  // base wait plus jitter, saturating at the 4-bit counter limit
  assign wait_sum  = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
  assign wait_load = (wait_sum > 5'd15) ? 4'd15 : wait_sum[3:0];
`else
  assign wait_load = 4'(WAIT_CYCLES);
`endif

  // Decode always works on the latched address so mid-request changes
  // from the master cannot affect the access.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH_WORDS));
  assign aligned  = (addr_q[1:0] == 2'b00);
  assign bad      = !in_range || !aligned || (is_rd_q && is_wr_q);
  assign idx      = IW'(offset >> 2);

  // next-state, request latching and handshake violation detection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    is_rd_d = is_rd_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = address;
          wdata_d = writedata;
          be_d    = byteenable;
          is_rd_d = read;
          is_wr_d = write;
          cnt_d   = wait_load;
          state_d = WAIT;
          if (read && write) perr_d = 1'b1;
        end
      end
      WAIT: begin
        if (!(read || write)) begin
          // master gave up: abort without touching memory
          state_d = IDLE;
          perr_d  = 1'b1;
        end else begin
          if (address != addr_q || writedata != wdata_q || byteenable != be_q)
            perr_d = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = DONE;
            rdata_d = (is_rd_q && !bad) ? mem[idx] : 32'h0;
            err_d   = bad;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      is_rd_q <= 1'b0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_rd_q <= is_rd_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
    end
  end

  // storage array: not reset; write commits on the edge leaving DONE
  always_ff @(posedge clk) begin
    if (state_q == DONE && is_wr_q && !bad)
      mem[idx] <= (mem[idx] & ~be_to_mask(be_q)) | (wdata_q & be_to_mask(be_q));
  end

  assign waitrequest  = (read || write) && (state_q != DONE);
  assign readdata     = rdata_q;
  assign err          = err_q;
  assign protocol_err = perr_q;

endmodule
